// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
//   Raster timing sequencer for the DVI output path. Free-running hc/vc
//   counters produce a fetch-side request stream (fetch, fetch_x/y,
//   line_start, frame_start) that runs LEAD cycles ahead of the pixel
//   source. A LEAD-stage delay line carries de/hs/vs so that the serializer
//   outputs line up with the pixel data coming back.
//
// Ports
//   clkp                   pixel clock (sole clock)
//   reset                  synchronous, active-high; overrides enable
//   enable                 1 = run raster, 0 = hold idle at origin
//   fetch, fetch_x/y       registered pixel request, coords 0 when idle
//   line_start             pulse with the fetch-side cycle at hc=0
//   frame_start            pulse with the fetch-side cycle at hc=0, vc=0
//   r_in/g_in/b_in         pixel data, valid LEAD cycles after its fetch
//   hsync, vsync, de       serializer timing, LEAD+1 cycles after fetch
//   r, g, b                serializer pixel data, black outside de
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int LEAD     = 2
) (
  input  logic       clkp,
  input  logic       reset,
  input  logic       enable,
  output logic       fetch,
  output logic [9:0] fetch_x,
  output logic [9:0] fetch_y,
  output logic       line_start,
  output logic       frame_start,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam logic [9:0] HA    = 10'(H_ACTIVE);
  localparam logic [9:0] HS0   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  localparam logic [9:0] VS0   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // delay-line slot layout
  localparam int DE = 2;
  localparam int HS = 1;
  localparam int VS = 0;

  logic       idle;
  logic [9:0] hc, vc;
  logic       act;
  logic       hs_f, vs_f;            // fetch-side sync, active-high internally
  logic [LEAD:1][2:0] dly;           // dly[k] valid k cycles after fetch side

  assign idle = reset || !enable;
  assign act  = (hc < HA) && (vc < VA);

  // Raster counters; held at origin while idle so a restart begins a frame.
  always_ff @(posedge clkp) begin
    if (idle) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HLAST) begin
      hc <= '0;
      vc <= (vc == VLAST) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Fetch side: registered view of the current counter position.
  always_ff @(posedge clkp) begin
    if (idle) begin
      fetch       <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_f        <= 1'b0;
      vs_f        <= 1'b0;
    end else begin
      fetch       <= act;
      fetch_x     <= act ? hc : 10'd0;
      fetch_y     <= act ? vc : 10'd0;
      line_start  <= (hc == 10'd0);
      frame_start <= (hc == 10'd0) && (vc == 10'd0);
      hs_f        <= (hc >= HS0) && (hc < HS1);
      // vc only moves at the hc wrap, so vsync is inherently line-based
      vs_f        <= (vc >= VS0) && (vc < VS1);
    end
  end

  // Timing delay line matching the upstream pixel latency.
  always_ff @(posedge clkp) begin
    if (idle) begin
      dly <= '0;
    end else begin
      dly[1] <= {fetch, hs_f, vs_f};
      for (int k = 2; k <= LEAD; k++) dly[k] <= dly[k-1];
    end
  end

  // Serializer side: pair the delayed timing with the returning pixel.
  always_ff @(posedge clkp) begin
    if (idle) begin
      de    <= 1'b0;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      de    <= dly[LEAD][DE];
      hsync <= dly[LEAD][HS] ? H_POL : ~H_POL;
      vsync <= dly[LEAD][VS] ? V_POL : ~V_POL;
      r     <= dly[LEAD][DE] ? r_in : 8'd0;
      g     <= dly[LEAD][DE] ? g_in : 8'd0;
      b     <= dly[LEAD][DE] ? b_in : 8'd0;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;
  // Shrunk raster so a few full frames fit in a short run.
  localparam int HA = 16, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 10, VFP = 2, VSY = 2, VBP = 3;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;
  localparam int LEAD = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int HIST = 8192;

  logic clkp = 1'b0;
  logic reset, enable;
  logic [7:0] r_in, g_in, b_in;
  logic fetch, line_start, frame_start, hsync, vsync, de;
  logic [9:0] fetch_x, fetch_y;
  logic [7:0] r, g, b;

  always #5 clkp = ~clkp;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL), .LEAD(LEAD)
  ) dut (
    .clkp(clkp), .reset(reset), .enable(enable),
    .fetch(fetch), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .line_start(line_start), .frame_start(frame_start),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b)
  );

  // Reference model: raster position shown on the fetch side (-1 = idle),
  // history of those positions, and edges since the last flush.
  int cyc = 0;
  int pos = -1;
  int since_flush = 0;
  int pos_hist [HIST];
  int total = 0, passed = 0, fails = 0;
  int de_total = 0;
  int fs_cyc[$];
  int fs_de[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input logic [23:0] rgb);
    int h, v, op, oh, ov;
    logic act, ode, ohs, ovs;
    // fetch side
    if (pos < 0) begin
      chk("fetch", fetch, 0);
      chk("fetch_x", fetch_x, 0);
      chk("fetch_y", fetch_y, 0);
      chk("line_start", line_start, 0);
      chk("frame_start", frame_start, 0);
    end else begin
      h = pos % HT;
      v = (pos / HT) % VT;
      act = (h < HA) && (v < VA);
      chk("fetch", fetch, act);
      chk("fetch_x", fetch_x, act ? h : 0);
      chk("fetch_y", fetch_y, act ? v : 0);
      chk("line_start", line_start, h == 0);
      chk("frame_start", frame_start, (h == 0) && (v == 0));
    end
    // serializer side: position fetched LEAD+1 cycles ago, if not flushed
    op = (since_flush > LEAD) ? pos_hist[cyc - LEAD - 1] : -1;
    if (op < 0) begin
      ode = 1'b0; ohs = 1'b0; ovs = 1'b0;
    end else begin
      oh = op % HT;
      ov = (op / HT) % VT;
      ode = (oh < HA) && (ov < VA);
      ohs = (oh >= HA + HFP) && (oh < HA + HFP + HSY);
      ovs = (ov >= VA + VFP) && (ov < VA + VFP + VSY);
    end
    chk("de", de, ode);
    chk("hsync", hsync, ohs ? HPOL : !HPOL);
    chk("vsync", vsync, ovs ? VPOL : !VPOL);
    chk("r", r, ode ? rgb[23:16] : 8'd0);
    chk("g", g, ode ? rgb[15:8] : 8'd0);
    chk("b", b, ode ? rgb[7:0] : 8'd0);
  endtask

  // One clock: drive inputs, advance the model, compare everything.
  task automatic step(input logic rst, input logic en, input logic ff);
    logic [23:0] rgb;
    rgb = ff ? 24'hFFFFFF : 24'($urandom);
    reset = rst;
    enable = en;
    {r_in, g_in, b_in} = rgb;
    @(posedge clkp);
    #1;
    cyc++;
    if (rst || !en) begin
      pos = -1;
      since_flush = 0;
    end else begin
      pos++;
      since_flush++;
    end
    if (cyc < HIST) pos_hist[cyc] = pos;
    check_all(rgb);
    if (de === 1'b1) de_total++;
    if (frame_start === 1'b1) begin
      fs_cyc.push_back(cyc);
      fs_de.push_back(de_total);
    end
  endtask

  // Run enabled until the fetch side shows raster position 'target'
  // (modulo 'modv'); bounded so a stuck design still reaches the summary.
  task automatic run_until(input string tag, input int target, input int modv);
    int n;
    n = 0;
    while (!(pos >= 0 && (pos % modv) == target) && n < 2000) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk(tag, n < 2000, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    {r_in, g_in, b_in} = '0;

    // reset state, then reset winning over enable, then plain idle
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // two full frames plus the wrap; alternate random and constant-white input
    for (int i = 0; i < 2 * HT * VT + 40; i++)
      step(1'b0, 1'b1, ((i / 200) % 2) == 1);

    // frame period and active pixels per frame
    chk("fs_count", fs_cyc.size() >= 2, 1'b1);
    if (fs_cyc.size() >= 2) begin
      chk("fs_period", fs_cyc[1] - fs_cyc[0], HT * VT);
      chk("de_per_frame", fs_de[1] - fs_de[0], HA * VA);
    end

    // drop enable mid-frame, mid-line; then restart from origin
    run_until("reach_mid", 5 * HT + 10, HT * VT);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (100) step(1'b0, 1'b1, 1'b1);

    // reset in the middle of hsync (enable still high)
    run_until("reach_hsync", HA + HFP + 2, HT);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b1, 1'b0);

    // random short enable drops
    for (int i = 0; i < 300; i++)
      step(1'b0, ($urandom % 40) != 0, ($urandom % 2) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
